// File: rtl/sseg_mux_n.sv
`default_nettype none
// ============================================================================
// Module   : sseg_mux_n
// Purpose  : N-digit multiplexed seven-segment driver for common-anode
//            displays. Each digit slot opens with a dead time (all digits
//            off) to suppress ghosting, then drives the selected digit from
//            a per-slot snapshot of its nibble and decimal point. Per-digit
//            blink and blank controls are applied live (through a single
//            register stage). All outputs are registered and active-low.
// Config   : SSEG_MUX_HEX_EN - when defined, nibbles 10-15 show A b C d E F;
//            otherwise they show a dash.
// Ports    : clock        - system clock
//            reset_n      - asynchronous active-low reset
//            enable       - low blanks the display and restarts the scan
//            digits       - packed nibbles, digit i at [4i+3:4i]
//            dp_in        - per-digit decimal point request (1 = lit)
//            blink        - per-digit blink request
//            blank        - per-digit forced-dark request
//            seg          - {g,f,e,d,c,b,a}, active-low
//            dp           - decimal point, active-low
//            an           - digit enables, active-low, at most one low
//            digit_strobe - one-cycle pulse at the start of every slot
// Revision : 1.0 - initial release
// ============================================================================
module sseg_mux_n #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_DIV    = 25000000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink,
  input  logic [DIGITS-1:0]     blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  digit_strobe
);

  // Counter widths; a 1-bit floor keeps degenerate parameter values legal.
  localparam int c_cnt_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_idx_w = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;
  localparam int c_bl_w  = (BLINK_DIV > 1)   ? $clog2(BLINK_DIV)   : 1;

  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(REFRESH_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_blank = c_cnt_w'(BLANK_CYCLES);
  localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(DIGITS - 1);
  localparam logic [c_bl_w-1:0]  c_bl_last   = c_bl_w'(BLINK_DIV - 1);

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_idx_w-1:0]   r_idx;
  logic [c_bl_w-1:0]    r_blink_cnt;
  logic                 r_phase;
  logic [3:0]           r_snap_nib;
  logic                 r_snap_dp;
  logic [DIGITS-1:0]    r_blink_q;
  logic [DIGITS-1:0]    r_blank_q;

  logic [c_cnt_w-1:0]   w_cnt_next;
  logic [3:0]           w_nib;
  logic                 w_dp_sel;
  logic                 w_blink_sel;
  logic                 w_blank_sel;
  logic [DIGITS-1:0]    w_an_drive;
  logic                 w_lit;
  logic [6:0]           w_seg_dec;

  // Segment patterns, {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
`ifdef SSEG_MUX_HEX_EN
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      default: pat = 7'b0001110;
`else
      default: pat = 7'b0111111;
`endif
    endcase
    return pat;
  endfunction

  assign w_cnt_next = r_cnt + 1'b1;

  // Select the current digit's data, blink/blank controls and anode pattern.
  always_comb begin
    w_nib       = 4'h0;
    w_dp_sel    = 1'b0;
    w_blink_sel = 1'b0;
    w_blank_sel = 1'b0;
    w_an_drive  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == c_idx_w'(i)) begin
        w_nib         = digits[4*i +: 4];
        w_dp_sel      = dp_in[i];
        w_blink_sel   = r_blink_q[i];
        w_blank_sel   = r_blank_q[i];
        w_an_drive[i] = 1'b0;
      end
    end
  end

  // A blinking digit is visible only during phase 1.
  assign w_lit     = !w_blank_sel && !(w_blink_sel && !r_phase);
  assign w_seg_dec = f_decode(r_snap_nib);

  // Slot scan: cnt/idx counters, slot FSM and per-slot data snapshot.
  // r_state tracks r_cnt so that DRIVE holds exactly when cnt >= BLANK_CYCLES.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_state    <= S_BLANK;
      r_snap_nib <= 4'h0;
      r_snap_dp  <= 1'b0;
    end else if (!enable) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_state <= S_BLANK;
    end else begin
      if (r_cnt == '0) begin
        r_snap_nib <= w_nib;
        r_snap_dp  <= w_dp_sel;
      end
      if (r_cnt == c_cnt_last) begin
        r_cnt   <= '0;
        r_state <= S_BLANK;
        r_idx   <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= w_cnt_next;
        if (w_cnt_next == c_cnt_blank) begin
          r_state <= S_DRIVE;
        end
      end
    end
  end

  // Blink timebase keeps running regardless of enable. blink/blank pass
  // through one register stage before use.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
      r_blink_q   <= '0;
      r_blank_q   <= '0;
    end else begin
      r_blink_q <= blink;
      r_blank_q <= blank;
      if (r_blink_cnt == c_bl_last) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // Registered, active-low outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      an           <= '1;
      seg          <= 7'h7F;
      dp           <= 1'b1;
      digit_strobe <= 1'b0;
    end else begin
      digit_strobe <= enable && (r_cnt == '0);
      if (enable && (r_state == S_DRIVE) && w_lit) begin
        an  <= w_an_drive;
        seg <= w_seg_dec;
        dp  <= ~r_snap_dp;
      end else begin
        an  <= '1;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sseg_mux_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_mux_n
// Purpose  : Self-checking bench for sseg_mux_n (DIGITS=4, REFRESH_DIV=8,
//            BLANK_CYCLES=2, BLINK_DIV=64). A cycle-level reference model
//            derives slot position, digit index and blink phase arithmetically
//            from elapsed clock counts and predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_mux_n;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int BD = 64;

`ifdef SSEG_MUX_HEX_EN
  localparam logic [6:0] REF_TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
`else
  localparam logic [6:0] REF_TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
`endif

  logic          clock   = 1'b0;
  logic          reset_n = 1'b1;
  logic          enable  = 1'b0;
  logic [15:0]   digits  = 16'h0;
  logic [3:0]    dp_in   = 4'h0;
  logic [3:0]    blink   = 4'h0;
  logic [3:0]    blank   = 4'h0;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          digit_strobe;

  int errors = 0;
  int checks = 0;

  // Reference model state: enabled cycles since scan restart, cycles since
  // reset, the current slot's latched data, and blink/blank seen last cycle.
  int          m_t;
  int          m_b;
  logic [3:0]  m_nib;
  logic        m_dp;
  logic [3:0]  m_bl_prev;
  logic [3:0]  m_bk_prev;

  sseg_mux_n #(
    .DIGITS       (D),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC),
    .BLINK_DIV    (BD)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .digits       (digits),
    .dp_in        (dp_in),
    .blink        (blink),
    .blank        (blank),
    .seg          (seg),
    .dp           (dp),
    .an           (an),
    .digit_strobe (digit_strobe)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t       = 0;
    m_b       = 0;
    m_nib     = 4'h0;
    m_dp      = 1'b0;
    m_bl_prev = 4'h0;
    m_bk_prev = 4'h0;
  endtask

  // One clock: sample inputs, wait past the edge, compare against the model.
  task automatic step();
    logic        en_s;
    logic [15:0] dig_s;
    logic [3:0]  dpi_s, bl_s, bk_s;
    int          cnt, idx;
    bit          phase;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_st;
    en_s  = enable;
    dig_s = digits;
    dpi_s = dp_in;
    bl_s  = blink;
    bk_s  = blank;
    @(posedge clock);
    #1;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    e_st  = 1'b0;
    if (en_s) begin
      cnt   = m_t % RD;
      idx   = (m_t / RD) % D;
      phase = ((m_b / BD) % 2) == 0;
      e_st  = (cnt == 0);
      if (cnt >= BC && !m_bk_prev[idx] && !(m_bl_prev[idx] && !phase)) begin
        e_an  = 4'hF & ~(4'b0001 << idx);
        e_seg = REF_TBL[m_nib];
        e_dp  = ~m_dp;
      end
      if (cnt == 0) begin
        m_nib = dig_s[4*idx +: 4];
        m_dp  = dpi_s[idx];
      end
      m_t++;
    end else begin
      m_t = 0;
    end
    m_b++;
    m_bl_prev = bl_s;
    m_bk_prev = bk_s;
    check("an",     32'(an),           32'(e_an));
    check("seg",    32'(seg),          32'(e_seg));
    check("dp",     32'(dp),           32'(e_dp));
    check("strobe", 32'(digit_strobe), 32'(e_st));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"},     32'(an),           32'hF);
    check({tag, "_seg"},    32'(seg),          32'h7F);
    check({tag, "_dp"},     32'(dp),           32'h1);
    check({tag, "_strobe"}, 32'(digit_strobe), 32'h0);
  endtask

  initial begin
    int guard;
    // Reset asserted before any clock edge: outputs must settle immediately.
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    @(posedge clock); @(posedge clock); #1;
    check_reset_outputs("rst_held");
    reset_n = 1'b1;
    model_reset();

    // Basic scan of 1234.
    enable = 1'b1;
    digits = 16'h1234;
    run(40);

    // Snapshot: modify digit 0 mid-slot 0.
    guard = 0;
    while (!((m_t % RD) == 3 && ((m_t / RD) % D) == 0) && guard < 64) begin
      step();
      guard++;
    end
    check("snap_reach", 32'(guard < 64), 32'h1);
    digits[3:0] = 4'h7;
    run(40);

    // Blink digit 0, blank digit 2, dp on digit 1.
    blink = 4'b0001;
    blank = 4'b0100;
    dp_in = 4'b0010;
    run(300);

    // Hex / dash decode.
    digits[3:0] = 4'hA;
    blink = 4'h0;
    blank = 4'h0;
    run(40);

    // Enable low mid-slot 2, then re-enable.
    guard = 0;
    while (!((m_t % RD) == 4 && ((m_t / RD) % D) == 2) && guard < 64) begin
      step();
      guard++;
    end
    check("en_reach", 32'(guard < 64), 32'h1);
    enable = 1'b0;
    run(3);
    enable = 1'b1;
    run(30);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(19) == 0) digits = 16'($urandom);
      if ($urandom_range(19) == 0) dp_in  = 4'($urandom);
      if ($urandom_range(29) == 0) blink  = 4'($urandom) & 4'($urandom);
      if ($urandom_range(29) == 0) blank  = 4'($urandom) & 4'($urandom);
      if ($urandom_range(39) == 0) enable = 1'b0;
      else if ($urandom_range(3) == 0) enable = 1'b1;
      step();
    end

    // Async reset between edges while a digit is lit.
    enable = 1'b1;
    blink  = 4'h0;
    blank  = 4'h0;
    guard  = 0;
    while (an == 4'hF && guard < 40) begin
      step();
      guard++;
    end
    check("drive_reach", 32'(guard < 40), 32'h1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(posedge clock); #1;
    reset_n = 1'b1;
    model_reset();
    run(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
